// File: rtl/clksel_sequencer.sv
`default_nettype none
// clksel_sequencer -- HS/LS clock-switch handshake initiator on hsclk_in (rev 1.0).
// Optional completed-switch counter is enabled by defining CLKSEL_SWITCH_STATS_EN.
module clksel_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LS_DWELL    = 8,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic             hsclk_in,
  input  logic             rst,
  input  logic             host_req,
  input  logic             force_ls,
  input  logic             err_clr,
  input  logic             hsclk_selected,
  input  logic             lsclk_selected,
  output logic             hsclk_sel,
  output logic             mode_hs,
  output logic             switching,
  output logic             timeout_err,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam int DWELL_W = (LS_DWELL < 1) ? 1 : $clog2(LS_DWELL + 1);
  localparam int TIMER_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(LS_DWELL);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    SW_HS  = 2'd1,
    HS_RUN = 2'd2,
    SW_LS  = 2'd3
  } state_t;

  state_t               state;
  logic [DWELL_W-1:0]   dwell;
  logic [TIMER_W-1:0]   timer;
  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                 hs_s;
  logic                 ls_s;
  logic                 hs_done;
  logic                 ls_done;

  // Feedback crosses from the switch's clock domain; only the last stage is used.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      hs_sync <= '0;
      ls_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  assign hs_s    = hs_sync[SYNC_STAGES-1];
  assign ls_s    = ls_sync[SYNC_STAGES-1];
  assign hs_done = hs_s & ~ls_s;
  assign ls_done = ls_s & ~hs_s;

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state       <= LS_RUN;
      hsclk_sel   <= 1'b0;
      mode_hs     <= 1'b0;
      switching   <= 1'b0;
      timeout_err <= 1'b0;
      dwell       <= DWELL_INIT;
      timer       <= '0;
    end else begin
      // A timeout raised below in the same cycle overrides this clear.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        LS_RUN: begin
          if (dwell != '0) dwell <= dwell - 1'b1;
          if (dwell == '0 && !host_req && !force_ls && !timeout_err) begin
            state     <= SW_HS;
            hsclk_sel <= 1'b1;
            switching <= 1'b1;
            timer     <= '0;
          end
        end
        SW_HS: begin
          timer <= timer + 1'b1;
          if (hs_done) begin
            state     <= HS_RUN;
            mode_hs   <= 1'b1;
            switching <= 1'b0;
          end else if (timer == TIMER_MAX) begin
            timeout_err <= 1'b1;
            hsclk_sel   <= 1'b0;
            state       <= SW_LS;
            timer       <= '0;
          end
        end
        HS_RUN: begin
          if (host_req || force_ls) begin
            hsclk_sel <= 1'b0;
            mode_hs   <= 1'b0;
            switching <= 1'b1;
            state     <= SW_LS;
            timer     <= '0;
          end
        end
        SW_LS: begin
          hsclk_sel <= 1'b0;
          if (ls_done) begin
            state     <= LS_RUN;
            switching <= 1'b0;
            dwell     <= DWELL_INIT;
          end else if (timer == TIMER_MAX) begin
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= LS_RUN;
          hsclk_sel <= 1'b0;
          mode_hs   <= 1'b0;
          switching <= 1'b0;
          dwell     <= DWELL_INIT;
        end
      endcase
    end
  end

`ifdef CLKSEL_SWITCH_STATS_EN
  logic switch_done;
  assign switch_done = (state == SW_HS && hs_done) || (state == SW_LS && ls_done);

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      switch_cnt <= '0;
    end else if (switch_done && switch_cnt != '1) begin
      switch_cnt <= switch_cnt + 1'b1;
    end
  end
`else
  assign switch_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clksel_sequencer.sv
`default_nettype none
// tb_clksel_sequencer -- directed bench for clksel_sequencer with a 2-cycle switch model.
module tb_clksel_sequencer;

`ifdef CLKSEL_SWITCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        hsclk_in = 1'b0;
  logic        rst;
  logic        host_req;
  logic        force_ls;
  logic        err_clr;
  logic        hsclk_selected = 1'b0;
  logic        lsclk_selected = 1'b1;
  logic        hsclk_sel;
  logic        mode_hs;
  logic        switching;
  logic        timeout_err;
  logic [15:0] switch_cnt;

  logic        sw_freeze = 1'b0;
  logic        sel_q = 1'b0;
  logic        seen;
  int          vectors = 0;
  int          miscompares = 0;

  clksel_sequencer dut (
    .hsclk_in       (hsclk_in),
    .rst            (rst),
    .host_req       (host_req),
    .force_ls       (force_ls),
    .err_clr        (err_clr),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .mode_hs        (mode_hs),
    .switching      (switching),
    .timeout_err    (timeout_err),
    .switch_cnt     (switch_cnt)
  );

  always #5 hsclk_in = ~hsclk_in;

  // Clock-switch model: feedback follows hsclk_sel two falling edges later unless frozen.
  always @(negedge hsclk_in) begin
    if (!sw_freeze) begin
      hsclk_selected = sel_q;
      lsclk_selected = !sel_q;
    end
    sel_q = hsclk_sel;
  end

  task automatic step(input int n);
    repeat (n) @(posedge hsclk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; host_req = 1'b0; force_ls = 1'b0; err_clr = 1'b0;
    step(3);
    check("rst_sel", hsclk_sel, 0);
    check("rst_mode", mode_hs, 0);
    check("rst_switching", switching, 0);
    check("rst_err", timeout_err, 0);
    check("rst_cnt", switch_cnt, 0);

    // Reset release: HS request on the 9th edge, HS_RUN four edges later.
    rst = 1'b0;
    step(8);
    check("boot_dwell_sel", hsclk_sel, 0);
    step(1);
    check("boot_sel_rise", hsclk_sel, 1);
    check("boot_switching", switching, 1);
    step(3);
    check("boot_mode_early", mode_hs, 0);
    step(1);
    check("boot_mode_hs", mode_hs, 1);
    check("boot_switch_done", switching, 0);
    check("boot_cnt", switch_cnt, cnt_exp(1));

    // host_req pulse in HS_RUN.
    step(2);
    host_req = 1'b1;
    step(1);
    host_req = 1'b0;
    check("hreq_sel_fall", hsclk_sel, 0);
    check("hreq_switching", switching, 1);
    check("hreq_mode", mode_hs, 0);
    step(3);
    check("hreq_still_sw", switching, 1);
    step(1);
    check("hreq_ls_done", switching, 0);
    check("hreq_cnt", switch_cnt, cnt_exp(2));

    // Freeze feedback at LS so the next HS request stalls.
    sw_freeze = 1'b1;
    step(8);
    check("dwell_reload_sel", hsclk_sel, 0);
    step(1);
    check("dwell_sel_rise", hsclk_sel, 1);
    seen = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      if (hsclk_sel !== 1'b1) seen = 1'b1;
    end
    check("to_sel_held", seen, 0);
    check("to_err_early", timeout_err, 0);
    step(1);
    check("to_err_set", timeout_err, 1);
    check("to_sel_fall", hsclk_sel, 0);
    check("to_switching", switching, 1);
    step(1);
    check("to_ls_done", switching, 0);
    check("to_cnt", switch_cnt, cnt_exp(3));
    sw_freeze = 1'b0;

    // Sticky error blocks HS until cleared.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (hsclk_sel !== 1'b0) seen = 1'b1;
    end
    check("err_blocks_hs", seen, 0);
    check("err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("err_cleared", timeout_err, 0);
    check("err_clr_sel", hsclk_sel, 0);
    step(1);
    check("err_rereq_sel", hsclk_sel, 1);

    // host_req raised during SW_HS: switch completes, one HS_RUN cycle, then SW_LS.
    host_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (hsclk_sel !== 1'b1 || mode_hs !== 1'b0) seen = 1'b1;
    end
    check("swhs_sel_stable", seen, 0);
    step(1);
    check("swhs_hs_run", mode_hs, 1);
    check("swhs_sel_hs", hsclk_sel, 1);
    check("swhs_cnt_hs", switch_cnt, cnt_exp(4));
    step(1);
    check("swhs_exit_mode", mode_hs, 0);
    check("swhs_exit_sel", hsclk_sel, 0);
    check("swhs_exit_sw", switching, 1);
    step(4);
    check("swhs_ls_done", switching, 0);
    check("swhs_cnt_ls", switch_cnt, cnt_exp(5));
    host_req = 1'b0;

    // Asynchronous reset in the middle of SW_HS.
    step(8);
    check("rst2_dwell_sel", hsclk_sel, 0);
    step(1);
    check("rst2_sel_rise", hsclk_sel, 1);
    step(1);
    rst = 1'b1;
    #1;
    check("arst_sel", hsclk_sel, 0);
    check("arst_mode", mode_hs, 0);
    check("arst_switching", switching, 0);
    check("arst_cnt", switch_cnt, 0);
    step(3);
    rst = 1'b0;
    step(8);
    check("reboot_dwell_sel", hsclk_sel, 0);
    step(1);
    check("reboot_sel_rise", hsclk_sel, 1);
    step(4);
    check("reboot_mode_hs", mode_hs, 1);
    check("reboot_cnt", switch_cnt, cnt_exp(1));

    // force_ls with LS feedback stuck: SW_LS timeout coincident with err_clr.
    sw_freeze = 1'b1;
    force_ls = 1'b1;
    step(1);
    check("fls_sel_fall", hsclk_sel, 0);
    check("fls_switching", switching, 1);
    step(255);
    check("swls_err_early", timeout_err, 0);
    check("swls_still_sw", switching, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("swls_err_wins", timeout_err, 1);
    check("swls_sel_low", hsclk_sel, 0);
    sw_freeze = 1'b0;
    step(3);
    check("swls_ls_done", switching, 0);
    check("swls_cnt", switch_cnt, cnt_exp(2));
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("swls_err_clr", timeout_err, 0);
    step(12);
    check("fls_pins_ls", hsclk_sel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
